// File: rtl/tremolo_lfo.sv
// LFO-driven amplitude modulation of CHANNELS signed samples per frame.
// One shared multiplier walks the channels; the product is registered before staging.
module tremolo_lfo #(
  parameter int unsigned DATA_WIDTH  = 24,
  parameter int unsigned CHANNELS    = 2,
  parameter int unsigned GAIN_WIDTH  = 16,
  parameter int unsigned PHASE_WIDTH = 24
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           enable,
  input  logic [1:0]                     shape,
  input  logic [PHASE_WIDTH-1:0]         rate,
  input  logic [GAIN_WIDTH-1:0]          depth,
  input  logic                           in_valid,
  input  logic [DATA_WIDTH*CHANNELS-1:0] in_data,
  output logic                           out_valid,
  output logic [DATA_WIDTH*CHANNELS-1:0] out_data,
  output logic                           busy,
  output logic                           overrun
);

  localparam int unsigned TOTAL = DATA_WIDTH * CHANNELS;
  localparam int unsigned CW    = $clog2(CHANNELS + 1);
  localparam int unsigned PW    = DATA_WIDTH + GAIN_WIDTH;
  localparam int unsigned GW2   = 2 * GAIN_WIDTH;
  localparam logic [GAIN_WIDTH:0] UNITY = {1'b1, {GAIN_WIDTH{1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, OUT} state_t;

  state_t                  state_q, state_d;
  logic [PHASE_WIDTH-1:0]  phase_q, phase_d;
  logic [GAIN_WIDTH:0]     gain_q, gain_d;
  logic [TOTAL-1:0]        in_q, in_d;
  logic [TOTAL-1:0]        stage_q, stage_d;
  logic [TOTAL-1:0]        out_q, out_d;
  logic [CW-1:0]           ch_q, ch_d;
  logic [DATA_WIDTH-1:0]   prod_q, prod_d;
  logic                    out_valid_q, out_valid_d;
  logic                    busy_q, busy_d;
  logic                    overrun_q, overrun_d;

  logic [GAIN_WIDTH-1:0]   lfo;
  logic [GW2-1:0]          depth_lfo;
  logic [GAIN_WIDTH:0]     gain_calc;
  logic [DATA_WIDTH-1:0]   x_cur;
  logic signed [PW-1:0]    x_ext;
  logic signed [PW-1:0]    g_ext;
  logic signed [PW-1:0]    full_p;

  always_comb begin
    unique case (shape)
      2'd1:    lfo = phase_q[PHASE_WIDTH-1] ? '0 : '1;
      2'd2:    lfo = ~phase_q[PHASE_WIDTH-1 -: GAIN_WIDTH];
      default: lfo = phase_q[PHASE_WIDTH-1] ? ~phase_q[PHASE_WIDTH-2 -: GAIN_WIDTH]
                                            :  phase_q[PHASE_WIDTH-2 -: GAIN_WIDTH];
    endcase
    depth_lfo = GW2'(depth) * GW2'(lfo);
    // (depth*L)>>G never reaches 2^G, so the subtraction cannot wrap.
    gain_calc = UNITY - (GAIN_WIDTH+1)'(depth_lfo >> GAIN_WIDTH);
  end

  always_comb begin
    x_cur = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ch_q == CW'(i)) x_cur = in_q[i*DATA_WIDTH +: DATA_WIDTH];
    end
    x_ext  = {{GAIN_WIDTH{x_cur[DATA_WIDTH-1]}}, x_cur};
    g_ext  = PW'(gain_q);
    full_p = x_ext * g_ext;
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    gain_d      = gain_q;
    in_d        = in_q;
    stage_d     = stage_q;
    out_d       = out_q;
    ch_d        = ch_q;
    prod_d      = prod_q;
    busy_d      = busy_q;
    out_valid_d = 1'b0;
    overrun_d   = in_valid && (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          in_d    = in_data;
          gain_d  = enable ? gain_calc : UNITY;
          phase_d = enable ? phase_q + rate : phase_q;
          ch_d    = '0;
          busy_d  = 1'b1;
          state_d = MUL;
        end
      end
      MUL: begin
        // Product of channel ch is registered; it lands in staging on the next cycle.
        if (ch_q < CW'(CHANNELS)) prod_d = DATA_WIDTH'(full_p >>> GAIN_WIDTH);
        for (int i = 0; i < CHANNELS; i++) begin
          if (ch_q == CW'(i + 1)) stage_d[i*DATA_WIDTH +: DATA_WIDTH] = prod_q;
        end
        if (ch_q == CW'(CHANNELS)) state_d = OUT;
        else                        ch_d    = ch_q + 1'b1;
      end
      OUT: begin
        out_d       = stage_q;
        out_valid_d = 1'b1;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      gain_q      <= '0;
      in_q        <= '0;
      stage_q     <= '0;
      out_q       <= '0;
      ch_q        <= '0;
      prod_q      <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      gain_q      <= gain_d;
      in_q        <= in_d;
      stage_q     <= stage_d;
      out_q       <= out_d;
      ch_q        <= ch_d;
      prod_q      <= prod_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_tremolo_lfo.sv
// Randomized and directed checks of tremolo_lfo against an arithmetic model
// of the gain law, frame latency, overrun and reset behaviour.
module tb_tremolo_lfo;

   localparam int D = 24;
   localparam int C = 2;
   localparam int G = 16;
   localparam int P = 24;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             enable;
   logic [1:0]       shape;
   logic [P-1:0]     rate;
   logic [G-1:0]     depth;
   logic             in_valid;
   logic [D*C-1:0]   in_data;
   logic             out_valid;
   logic [D*C-1:0]   out_data;
   logic             busy;
   logic             overrun;

   int               total = 0;
   int               bad = 0;
   longint           modelPhase = 0;

   always #5 clk = ~clk;

   tremolo_lfo #(.DATA_WIDTH(D), .CHANNELS(C), .GAIN_WIDTH(G), .PHASE_WIDTH(P)) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .shape(shape), .rate(rate),
      .depth(depth), .in_valid(in_valid), .in_data(in_data), .out_valid(out_valid),
      .out_data(out_data), .busy(busy), .overrun(overrun)
   );

   // Counts one comparison and reports it if the observed value differs.
   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Gain as an integer: unity minus depth-scaled LFO level derived from phase.
   function automatic longint modelGain(input logic [1:0] sh, input longint dp, input logic en,
                                        input longint ph);
      longint lv, s, t;
      bit top;
      if (!en) return 65536;
      top = ((ph >> 23) & 1) != 0;
      s = (ph >> 7) & 'hFFFF;
      t = (ph >> 8) & 'hFFFF;
      case (sh)
         2'd1:    lv = top ? 0 : 65535;
         2'd2:    lv = 65535 - t;
         default: lv = top ? 65535 - s : s;
      endcase
      return 65536 - (dp * lv) / 65536;
   endfunction

   function automatic logic [23:0] modelSample(input logic signed [23:0] x, input longint g);
      longint p;
      p = longint'(x) * g;
      return 24'(p >>> 16);
   endfunction

   // Sends one frame, scrambles the control inputs mid-frame, and checks timing and data.
   task automatic applyStimulus(input string tag, input logic [1:0] sh, input logic [23:0] rt,
                                input logic [15:0] dp, input logic en,
                                input logic signed [23:0] x0, input logic signed [23:0] x1);
      longint g;
      logic [47:0] exp;
      int cyc;
      g   = modelGain(sh, dp, en, modelPhase);
      exp = {modelSample(x1, g), modelSample(x0, g)};
      if (en) modelPhase = (modelPhase + rt) % 64'd16777216;
      @(negedge clk);
      shape = sh; rate = rt; depth = dp; enable = en; in_data = {x1, x0}; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      shape = 2'($urandom); rate = 24'($urandom); depth = 16'($urandom); enable = 1'($urandom);
      checkOutput({tag, ".busy"}, busy, 1);
      cyc = 0;
      while (!out_valid && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      checkOutput({tag, ".lat"}, cyc, 4);
      checkOutput({tag, ".data"}, out_data, exp);
      checkOutput({tag, ".busy_end"}, busy, 0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog got=timeout exp=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      longint g;
      logic [47:0] exp;
      logic [47:0] got;
      int nValid;

      reset_n = 1'b0; enable = 1'b1; shape = 2'd0; rate = '0; depth = '0;
      in_valid = 1'b0; in_data = '0;
      #12;
      checkOutput("rst.valid", out_valid, 0);
      checkOutput("rst.busy", busy, 0);
      checkOutput("rst.ovr", overrun, 0);
      checkOutput("rst.data", out_data, 0);
      @(negedge clk);
      reset_n = 1'b1;

      applyStimulus("unity", 2'd0, 24'h0, 16'h0, 1'b1, 24'h100000, -24'sh100000);
      checkOutput("unity.const", out_data, {-24'sh100000, 24'h100000});

      applyStimulus("square", 2'd1, 24'h0, 16'hFFFF, 1'b1, 24'h100000, -24'sh100000);
      checkOutput("square.const", out_data, {-24'sh000020, 24'h000020});

      for (int i = 0; i < 5; i++) begin
         applyStimulus("tri", 2'd0, 24'h400000, 16'hFFFF, 1'b1, 24'h100000, 24'h100000);
         if (i == 1) checkOutput("tri.f2", out_data[23:0], 24'h080010);
      end

      // Overrun: a second strobe two cycles after acceptance must be dropped.
      g   = modelGain(2'd0, 16'hFFFF, 1'b1, modelPhase);
      exp = {modelSample(-24'sh0ABCDE, g), modelSample(24'h123456, g)};
      modelPhase = (modelPhase + 24'h200000) % 64'd16777216;
      @(negedge clk);
      shape = 2'd0; rate = 24'h200000; depth = 16'hFFFF; enable = 1'b1;
      in_data = {-24'sh0ABCDE, 24'h123456}; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      in_valid = 1'b1; in_data = {24'h7FFFFF, 24'h7FFFFF};
      @(negedge clk);
      in_valid = 1'b0;
      checkOutput("ovr.pulse", overrun, 1);
      nValid = 0; got = '0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (out_valid) begin
            nValid++;
            got = out_data;
         end
      end
      checkOutput("ovr.count", nValid, 1);
      checkOutput("ovr.data", got, exp);
      applyStimulus("ovr.next", 2'd0, 24'h200000, 16'hFFFF, 1'b1, 24'h100000, -24'sh100000);

      for (int i = 0; i < 3; i++)
         applyStimulus("bypass", 2'd0, 24'h100000, 16'hFFFF, 1'b0, 24'($urandom), 24'($urandom));
      applyStimulus("bypass.resume", 2'd2, 24'h100000, 16'hFFFF, 1'b1, 24'h200000, 24'h0FFFFF);

      // Reset while the frame is in the multiply phase.
      @(negedge clk);
      shape = 2'd1; depth = 16'h8000; enable = 1'b1; rate = 24'h123456;
      in_data = {24'h345678, 24'h654321}; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      checkOutput("midrst.data", out_data, 0);
      checkOutput("midrst.busy", busy, 0);
      checkOutput("midrst.valid", out_valid, 0);
      modelPhase = 0;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      nValid = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (out_valid) nValid++;
      end
      checkOutput("midrst.novalid", nValid, 0);
      applyStimulus("postrst1", 2'd0, 24'h300000, 16'hFFFF, 1'b1, 24'h100000, -24'sh100000);
      applyStimulus("postrst2", 2'd0, 24'h300000, 16'hFFFF, 1'b1, 24'h100000, -24'sh100000);

      for (int i = 0; i < 24; i++)
         applyStimulus("rand", 2'($urandom_range(0, 3)), 24'($urandom), 16'($urandom),
                       1'($urandom_range(0, 3) != 0), 24'($urandom), 24'($urandom));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
